// File: rtl/result_converter_pkg.sv
// Shared constants, FSM encodings and float layout for the sin/cos result converter.
package result_converter_pkg;

  localparam int          FLOAT_BIAS = 127;
  localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ROTATE = 3'd1,
    ST_ABS    = 3'd2,
    ST_NORM   = 3'd3,
    ST_PACK   = 3'd4,
    ST_DONE   = 3'd5,
    ST_CONV   = 3'd6
  } state_t;

  typedef struct packed {
    logic        sgn;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float_t;

  // Fraction bits of the Q2.(WIDTH-2) cordic output format.
  function automatic int frac_bits(input int width);
    return width - 2;
  endfunction

endpackage

// File: rtl/result_converter_if.sv
// Input/output bundle of result_converter: cordic result in, IEEE floats out.
interface result_converter_if #(
  parameter int WIDTH = 16
);
  logic                    valid_in;
  logic signed [WIDTH-1:0] sin_in;
  logic signed [WIDTH-1:0] cos_in;
  logic signed [2:0]       flip;
  logic [31:0]             sin_out;
  logic [31:0]             cos_out;
  logic                    valid_out;
  logic                    ready;

  modport master (
    output valid_in, sin_in, cos_in, flip,
    input  sin_out, cos_out, valid_out, ready
  );

  modport slave (
    input  valid_in, sin_in, cos_in, flip,
    output sin_out, cos_out, valid_out, ready
  );
endinterface

// File: rtl/result_converter_fixed_to_float.sv
// One-channel signed Q2.(WIDTH-2) to IEEE single converter; 2+z cycles (ABS, z NORM, PACK).
// No backpressure: float_out is valid only while done is high; start in PACK chains the next value.
module fixed_to_float
  import result_converter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] value,
  output logic [31:0]             float_out,
  output logic                    done
);

  // 1.0 sits at bit FRAC_BITS; after shifting the msb to bit WIDTH-1 the exponent must land on 127.
  localparam logic [7:0] EXP_INIT = 8'(FLOAT_BIAS + (WIDTH - 1) - frac_bits(WIDTH));

  state_t           state_q, state_d;
  logic             sgn_q;
  logic [WIDTH-1:0] mag_q;
  logic [7:0]       exp_q;
  logic [WIDTH-1:0] abs_val;
  logic [22:0]      frac;
  float_t           packed_f;

  // Most negative input maps to 2^(WIDTH-1), which still fits as unsigned.
  assign abs_val = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;
  assign frac    = 23'(mag_q[WIDTH-2:0]) << (24 - WIDTH);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_ABS;
      ST_ABS:  state_d = ((abs_val == '0) || abs_val[WIDTH-1]) ? ST_PACK : ST_NORM;
      ST_NORM: state_d = mag_q[WIDTH-2] ? ST_PACK : ST_NORM;
      ST_PACK: state_d = start ? ST_ABS : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_q <= 1'b0;
      mag_q <= '0;
      exp_q <= '0;
    end else if (state_q == ST_ABS) begin
      sgn_q <= value[WIDTH-1];
      mag_q <= abs_val;
      exp_q <= EXP_INIT;
    end else if (state_q == ST_NORM) begin
      mag_q <= {mag_q[WIDTH-2:0], 1'b0};
      exp_q <= exp_q - 8'd1;
    end
  end

  always_comb begin
    packed_f.sgn  = sgn_q;
    packed_f.exp  = exp_q;
    packed_f.frac = frac;
  end

  // Zero drops its sign so -0.0 never leaves the block.
  assign float_out = (mag_q == '0) ? FLOAT_ZERO : packed_f;
  assign done      = (state_q == ST_PACK);

endmodule

// File: rtl/result_converter.sv
// Undoes the quadrant fold of a cordic sin/cos pair and emits both as IEEE floats; 6+z_sin+z_cos cycles.
// ready is high only in IDLE; valid_out is a one-cycle pulse with no downstream stall.
module result_converter
  import result_converter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  result_converter_if.slave bus
);

  typedef struct packed {
    logic signed [WIDTH-1:0] sin_v;
    logic signed [WIDTH-1:0] cos_v;
  } pair_t;

  localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] sat_neg(input logic signed [WIDTH-1:0] v);
    return (v == MIN_NEG) ? MAX_POS : -v;
  endfunction

  state_t                  state_q, state_d;
  pair_t                   in_q, rot_q, rot_d;
  logic [2:0]              k_q;
  logic                    ch_q;
  logic [31:0]             sin_res_q, sin_out_q, cos_out_q;
  logic                    f2f_start, f2f_done;
  logic [31:0]             f2f_float;
  logic signed [WIDTH-1:0] f2f_value;
  logic [2:0]              neg_flip;

  // Rotation count is -flip mod 4; only the low two bits matter.
  assign neg_flip = 3'd0 - bus.flip;

  always_comb begin
    rot_d = in_q;
    casez (k_q)
      3'b?01: begin rot_d.sin_v = in_q.cos_v;          rot_d.cos_v = sat_neg(in_q.sin_v); end
      3'b?10: begin rot_d.sin_v = sat_neg(in_q.sin_v); rot_d.cos_v = sat_neg(in_q.cos_v); end
      3'b?11: begin rot_d.sin_v = sat_neg(in_q.cos_v); rot_d.cos_v = in_q.sin_v;          end
      default: rot_d = in_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    f2f_start = 1'b0;
    case (state_q)
      ST_IDLE:   if (bus.valid_in) state_d = ST_ROTATE;
      ST_ROTATE: begin
        f2f_start = 1'b1;
        state_d   = ST_CONV;
      end
      ST_CONV: begin
        // Chain cos straight out of the sin PACK cycle so no idle cycle is inserted.
        if (f2f_done) begin
          if (!ch_q) f2f_start = 1'b1;
          else       state_d   = ST_DONE;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q      <= '0;
      rot_q     <= '0;
      k_q       <= '0;
      ch_q      <= 1'b0;
      sin_res_q <= FLOAT_ZERO;
      sin_out_q <= FLOAT_ZERO;
      cos_out_q <= FLOAT_ZERO;
    end else begin
      if (state_q == ST_IDLE && bus.valid_in) begin
        in_q.sin_v <= bus.sin_in;
        in_q.cos_v <= bus.cos_in;
        k_q        <= neg_flip;
      end
      if (state_q == ST_ROTATE) begin
        rot_q <= rot_d;
        ch_q  <= 1'b0;
      end
      if (state_q == ST_CONV && f2f_done) begin
        if (!ch_q) begin
          sin_res_q <= f2f_float;
          ch_q      <= 1'b1;
        end else begin
          sin_out_q <= sin_res_q;
          cos_out_q <= f2f_float;
        end
      end
    end
  end

  assign f2f_value = ch_q ? rot_q.cos_v : rot_q.sin_v;

  fixed_to_float #(.WIDTH(WIDTH)) u_f2f (
    .clk       (clk),
    .rst       (rst),
    .start     (f2f_start),
    .value     (f2f_value),
    .float_out (f2f_float),
    .done      (f2f_done)
  );

  assign bus.ready     = (state_q == ST_IDLE);
  assign bus.valid_out = (state_q == ST_DONE);
  assign bus.sin_out   = sin_out_q;
  assign bus.cos_out   = cos_out_q;

endmodule

// File: tb/tb_result_converter.sv
// Directed bench for result_converter: fold undo, float packing, latency, handshake and reset abort.
module tb_result_converter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  result_converter_if #(.WIDTH(16)) bus ();

  result_converter #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  // Called at a negedge; returns at the negedge after the valid_out pulse.
  task automatic run(input string tag, input int s, input int c, input int f,
                     input logic [31:0] exp_sin, input logic [31:0] exp_cos, input int exp_lat);
    int n;
    int lat;
    int busy_rdy;
    bit found;
    n = 0;
    while (!bus.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(bus.ready), 32'd1);
    bus.sin_in   = 16'(s);
    bus.cos_in   = 16'(c);
    bus.flip     = 3'(f);
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1 bus.valid_in = 1'b0;
    lat = 0;
    busy_rdy = 0;
    found = 1'b0;
    while (!found && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.valid_out) found = 1'b1;
      else if (bus.ready) busy_rdy++;
    end
    chk({tag, "_valid"}, 32'(found), 32'd1);
    chk({tag, "_sin"}, bus.sin_out, exp_sin);
    chk({tag, "_cos"}, bus.cos_out, exp_cos);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_rdy"}, 32'(busy_rdy), 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.valid_out), 32'd0);
  endtask

  initial begin
    int acc;
    int pulses;
    int stray;
    bus.valid_in = 1'b0;
    bus.sin_in   = '0;
    bus.cos_in   = '0;
    bus.flip     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_sin", bus.sin_out, 32'h0000_0000);
    chk("rst_cos", bus.cos_out, 32'h0000_0000);

    run("one",      0,      16384,  0, 32'h0000_0000, 32'h3F80_0000, 7);
    run("diag",     11585,  11585,  0, 32'h3F35_0400, 32'h3F35_0400, 10);
    run("diag_f2",  11585,  11585,  2, 32'hBF35_0400, 32'hBF35_0400, 10);
    run("k1",       0,      16384, -1, 32'h3F80_0000, 32'h0000_0000, 7);
    run("k3",       0,      16384,  1, 32'hBF80_0000, 32'h0000_0000, 7);
    run("sat",      8192,  -32768,  2, 32'hBF00_0000, 32'h3FFF_FE00, 9);
    run("f3",       8192,   16384,  3, 32'h3F80_0000, 32'hBF00_0000, 9);
    run("fm4",     -32768,  1,     -4, 32'hC000_0000, 32'h3880_0000, 21);

    // valid_in held high: one accept per 8-cycle round, one pulse per accept.
    bus.sin_in   = 16'sd0;
    bus.cos_in   = 16'sd16384;
    bus.flip     = 3'sd0;
    bus.valid_in = 1'b1;
    acc = 0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ready && bus.valid_in) acc++;
      if (bus.valid_out) pulses++;
      if (i == 39) bus.valid_in = 1'b0;
      @(negedge clk);
    end
    chk("b2b_accepts", 32'(acc), 32'd5);
    chk("b2b_pulses", 32'(pulses), 32'd5);
    chk("b2b_ready", 32'(bus.ready), 32'd1);
    chk("b2b_cos", bus.cos_out, 32'h3F80_0000);

    // Abort while the sin channel is normalising.
    bus.sin_in   = 16'sd1;
    bus.cos_in   = 16'sd1;
    bus.flip     = 3'sd0;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1 bus.valid_in = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_valid", 32'(bus.valid_out), 32'd0);
    chk("abort_sin", bus.sin_out, 32'h0000_0000);
    chk("abort_cos", bus.cos_out, 32'h0000_0000);
    stray = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.valid_out) stray++;
      @(negedge clk);
    end
    chk("abort_stray", 32'(stray), 32'd0);

    run("post", 11585, 11585, 2, 32'hBF35_0400, 32'hBF35_0400, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
